// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan scheduler: FSM encoding,
// channel/data widths, default timing and the channel priority encoder.
package adc_pkg;

  localparam int NUM_CH             = 8;
  localparam int CH_W               = 3;
  localparam int DATA_W             = 12;
  localparam int DEF_PERIOD_CYCLES  = 50000;
  localparam int DEF_TIMEOUT_CYCLES = 12000;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    WAIT_DONE,
    PUSH
  } state_t;

  // Index of the lowest set bit; returns 0 for an empty mask.
  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Free-running scan period timer: counts 0..PERIOD_CYCLES-1 while enabled,
// held at zero otherwise, and flags the last count as the scan tick.
module adc_tick_gen
  import adc_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/adc_scan_scheduler.sv
// Walks the enabled ADC channels in ascending order, drives the conversion
// engine handshake and streams each result out on a valid/ready port.
module adc_scan_scheduler
  import adc_pkg::*;
#(
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              single_shot,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              conv_start,
  output logic [CH_W-1:0]   conv_ch,
  input  logic              conv_busy,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] conv_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [DATA_W-1:0] res_data,
  output logic              scan_done,
  output logic              overrun,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_n;
  logic              tick;
  logic              ss_mode;
  logic              timed_out;
  logic              next_ch;
  logic              scan_end;
  logic [NUM_CH-1:0] mask_lat;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   sel_ch;
  logic [TMO_W-1:0]  tmo_cnt;

  adc_tick_gen #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  assign sel_ch    = lowest_set(mask_lat);
  assign timed_out = (state == WAIT_DONE) && !conv_done && (tmo_cnt == TMO_LAST);
  assign next_ch   = timed_out || (state == PUSH && res_ready);
  // A scan only completes once every latched channel has been consumed.
  assign scan_end  = next_ch && (mask_lat == '0);

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    conv_start = 1'b0;
    case (state)
      IDLE:      if ((tick || single_shot) && ch_mask != '0) state_n = SELECT;
      SELECT:    state_n = START;
      START: begin
        if (!conv_busy) begin
          conv_start = 1'b1;
          state_n    = WAIT_DONE;
        end
      end
      WAIT_DONE: if (conv_done) state_n = PUSH;
      PUSH:      state_n = PUSH;
      default:   state_n = IDLE;
    endcase
    // Periodic scans are abandoned once enable drops; single-shot scans run out.
    if (next_ch) state_n = (mask_lat != '0 && (enable || ss_mode)) ? SELECT : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mask_lat    <= '0;
      ss_mode     <= 1'b0;
      cur_ch      <= '0;
      tmo_cnt     <= '0;
      res_ch      <= '0;
      res_data    <= '0;
      scan_done   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      scan_done   <= scan_end;
      overrun     <= (tick && state != IDLE) || (overrun && !err_clr);
      timeout_err <= timed_out || (timeout_err && !err_clr);

      if (state == IDLE && state_n == SELECT) begin
        mask_lat <= ch_mask;
        ss_mode  <= !tick;
      end
      if (state == SELECT) begin
        cur_ch   <= sel_ch;
        mask_lat <= mask_lat & ~(NUM_CH'(1) << sel_ch);
      end

      if (conv_start) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_DONE) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      if (state == WAIT_DONE && conv_done) begin
        res_ch   <= cur_ch;
        res_data <= conv_data;
      end
    end
  end

  assign conv_ch   = cur_ch;
  assign res_valid = (state == PUSH);

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
Sequences periodic multi-channel scans of the SPI ADC through the existing 12-bit conversion engine, using a start/busy/done handshake. It walks the enabled channels in ascending order and issues one conversion per channel. Each result is presented on a valid/ready stream to downstream logic. Overrun, timeout and backpressure are detected and flagged.

Parameters:
NUM_CH, 8, number of ADC channels; the channel index is 3 bits wide.
DATA_W, 12, conversion result width.
PERIOD_CYCLES, 50000, clk cycles between scan ticks (1 kHz at 50 MHz).
TIMEOUT_CYCLES, 12000, maximum clk cycles from conv_start to conv_done; one engine conversion is 11000 cycles.

Ports:
clk  in  1  50 MHz system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  enables the periodic tick timer
single_shot  in  1  one-cycle pulse; requests one scan when IDLE
ch_mask  in  NUM_CH  enabled channels; latched at scan start
conv_start  out  1  one-cycle start pulse to the conversion engine
conv_ch  out  3  channel for the engine; stable from conv_start until done or timeout
conv_busy  in  1  engine busy
conv_done  in  1  one-cycle pulse; conv_data is valid in the same cycle
conv_data  in  DATA_W  engine result
res_valid  out  1  result available
res_ready  in  1  downstream accepts the result
res_ch  out  3  channel of the result
res_data  out  DATA_W  result data
scan_done  out  1  one-cycle pulse after the last channel of a scan
overrun  out  1  sticky: a tick arrived while not IDLE
timeout_err  out  1  sticky: conv_done was missing
err_clr  in  1  clears overrun and timeout_err

Behaviour:
- Reset (async, rst=1): FSM to IDLE, timer=0, mask_lat=0. All outputs 0.
- Timer:
  - Counts 0..PERIOD_CYCLES-1 while enable=1 and is held at 0 while enable=0.
  - tick is high for the one cycle in which count==PERIOD_CYCLES-1.
- Scan request = tick, or single_shot while IDLE. single_shot works even with enable=0.
- FSM states: IDLE, SELECT, START, WAIT_DONE, PUSH.
- IDLE:
  - On a scan request with ch_mask!=0: latch mask_lat=ch_mask and go to SELECT.
  - A request with ch_mask=0: ignored; no scan_done.
- SELECT:
  - cur_ch = lowest set bit of mask_lat; clear that bit; go to START.
- START:
  - If conv_busy=0: assert conv_start for one cycle with conv_ch=cur_ch, reset the timeout counter, go to WAIT_DONE.
  - If conv_busy=1: hold in START with conv_start=0.
  - Latency: request at edge T -> conv_start high in cycle T+2 when the engine is idle.
- WAIT_DONE:
  - On conv_done: capture conv_data into res_data, res_ch=cur_ch, go to PUSH. res_valid is high the cycle after conv_done.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 first: set timeout_err, produce no result, and take the next-channel path.
- PUSH:
  - res_valid, res_ch and res_data are held stable until res_ready=1.
  - A handshake in the same cycle res_valid rises is permitted.
  - Backpressure stalls the scan; no result is ever dropped.
- Next-channel path (after an accepted result or a timeout):
  - If mask_lat!=0 and enable or single-shot mode still applies: go to SELECT.
  - Otherwise: pulse scan_done and go to IDLE.
- Deasserting enable mid-scan:
  - The current conversion finishes and its result is delivered.
  - Remaining channels are abandoned and the FSM returns to IDLE without scan_done.
  - A single-shot scan is not affected by enable.
- A tick while not IDLE sets overrun and is dropped; no queued scan.
- overrun and timeout_err are cleared by err_clr. If set and clear occur in the same cycle, set wins.
- A conv_done outside WAIT_DONE is ignored.
- Reset asserted mid-conversion: return to IDLE immediately; the engine is expected to be reset by the same rst.
- Widths: both counters are sized to ceil(log2(param)). No arithmetic on data.

Decomposition:
- Shared package adc_pkg:
  - FSM state encoding.
  - NUM_CH and DATA_W constants.
  - Default PERIOD_CYCLES and TIMEOUT_CYCLES.
  - Lowest-set-bit priority-encode function returning a 3-bit index.
- One sub-module, adc_tick_gen: the period counter. Inputs clk, rst, enable; output tick.

Test Plan:
All scenarios use PERIOD_CYCLES=200, TIMEOUT_CYCLES=50 and an engine model with done 20 cycles after start.
- Scan order: ch_mask=8'b1010_0101, enable=1, res_ready=1. Results arrive for ch 0,2,5,7 in that order, res_data equals the model value per channel, then one scan_done pulse.
- Timing: conv_start is exactly 2 cycles after tick, and res_valid is 1 cycle after conv_done.
- Backpressure: hold res_ready=0 for 30 cycles on ch 2 of mask 8'h05. res_valid, res_ch=2 and res_data stay stable throughout; no second conv_start occurs.
- Overrun: mask=8'hFF with res_ready=0 for 300 cycles. overrun=1 after the second tick; err_clr pulse -> overrun=0.
- Timeout: the model never returns done for ch 3 of mask 8'h18. timeout_err=1 at 50 cycles; ch 4 converts next; no result for ch 3; scan_done pulses.
- Busy, single-shot and reset: conv_busy=1 for 40 cycles delays conv_start until the cycle after busy drops. single_shot with enable=0 and mask=8'h01 produces exactly one scan. rst asserted in WAIT_DONE forces all outputs to 0 and the FSM to IDLE asynchronously.
